// File: rtl/muldiv_seq_unit.sv
// Sequential multiply/divide unit: pipelined multiplier plus radix-2 restoring divider.
// Optional define MULDIV_DIV_EARLY_OUT_EN: divides with |a| < |b| finish on the fast path.
module muldiv_seq_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned PRF_W      = 6,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic [2:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [PRF_W-1:0] req_rd_i,
    output logic             ready_o,
    input  logic             stall_i,
    input  logic             kill_i,
    output logic             early_wake_o,
    output logic             wb_valid_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [PRF_W-1:0] wb_rd_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int unsigned CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned PW      = 2 * XLEN;

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [XLEN-1:0]  r_a;      // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0]  r_b;      // multiplier, or divisor magnitude
    logic [XLEN-1:0]  r_rem;
    logic             r_neg_q, r_neg_r;
    logic [XLEN-1:0]  r_wb_data;
    logic [TAG_W-1:0] r_tag;
    logic [PRF_W-1:0] r_rd;

    logic             w_accept, w_req_sgn, w_a_neg, w_b_neg;
    logic             w_b_zero, w_ovf, w_small, w_fast;
    logic [XLEN-1:0]  w_a_mag, w_b_mag, w_fast_data;
    logic             w_ma_sgn, w_mb_sgn;
    logic [PW-1:0]    w_ma, w_mb, w_prod;
    logic [XLEN-1:0]  w_mul_res;
    logic [XLEN:0]    w_rem_sh, w_diff;
    logic             w_q_bit;
    logic [XLEN-1:0]  w_rem_nxt, w_quo_fix, w_rem_fix;

    // Request decode and divide fast-path detection (uses raw request operands)
    assign w_accept  = req_valid_i && (r_state == S_IDLE) && !stall_i && !kill_i;
    assign w_req_sgn = !req_op_i[0];
    assign w_a_neg   = w_req_sgn & req_a_i[XLEN-1];
    assign w_b_neg   = w_req_sgn & req_b_i[XLEN-1];
    assign w_a_mag   = w_a_neg ? (-req_a_i) : req_a_i;
    assign w_b_mag   = w_b_neg ? (-req_b_i) : req_b_i;
    assign w_b_zero  = (req_b_i == '0);
    assign w_ovf     = w_req_sgn && (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1);
`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign w_small   = !w_b_zero && (w_a_mag < w_b_mag);
`else
    assign w_small   = 1'b0;
`endif
    assign w_fast    = w_b_zero || w_ovf || w_small;

    always_comb begin
        w_fast_data = req_op_i[1] ? req_a_i : '0;
        if (w_b_zero)   w_fast_data = req_op_i[1] ? req_a_i : '1;
        else if (w_ovf) w_fast_data = req_op_i[1] ? '0 : req_a_i;
    end

    // Product over 2*XLEN bits; MULH and MULHSU treat rs1 as signed, only MULH treats rs2 as signed
    assign w_ma_sgn  = (r_op == 2'b01) || (r_op == 2'b10);
    assign w_mb_sgn  = (r_op == 2'b01);
    assign w_ma      = {{XLEN{r_a[XLEN-1] & w_ma_sgn}}, r_a};
    assign w_mb      = {{XLEN{r_b[XLEN-1] & w_mb_sgn}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];

    // One restoring-division step
    assign w_rem_sh  = {r_rem, r_a[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_q_bit   = !w_diff[XLEN];
    assign w_rem_nxt = w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_fix = r_neg_q ? (-r_a) : r_a;
    assign w_rem_fix = r_neg_r ? (-r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        ready_o      = (r_state == S_IDLE);
        wb_valid_o   = (r_state == S_DONE) && !kill_i;
        early_wake_o = (((r_state == S_MUL) && (r_cnt == '0)) || (r_state == S_FIX)) && !kill_i;
        if (kill_i) begin
            w_state_nxt = S_IDLE;
        end else if (!stall_i) begin
            case (r_state)
                S_IDLE: if (req_valid_i) w_state_nxt = !req_op_i[2] ? S_MUL : (w_fast ? S_DONE : S_DIV);
                S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
                S_DIV:  if (r_cnt == '0) w_state_nxt = S_FIX;
                S_FIX:  w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath; frozen on stall, irrelevant after kill since IDLE reloads on the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_wb_data <= '0;
            r_tag     <= '0;
            r_rd      <= '0;
        end else if (!stall_i && !kill_i) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op  <= req_op_i[1:0];
                    r_tag <= req_tag_i;
                    r_rd  <= req_rd_i;
                    if (!req_op_i[2]) begin
                        r_a   <= req_a_i;
                        r_b   <= req_b_i;
                        r_cnt <= CNT_W'(MUL_STAGES - 1);
                    end else begin
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_rem   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= CNT_W'(XLEN - 1);
                        if (w_fast) r_wb_data <= w_fast_data;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) r_wb_data <= w_mul_res;
                    else             r_cnt     <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    r_a   <= {r_a[XLEN-2:0], w_q_bit};
                    r_rem <= w_rem_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: r_wb_data <= r_op[1] ? w_rem_fix : w_quo_fix;
                default: ;
            endcase
        end
    end

    assign wb_data_o = r_wb_data;
    assign wb_tag_o  = r_tag;
    assign wb_rd_o   = r_rd;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed testbench for muldiv_seq_unit (XLEN=32, MUL_STAGES=2), hand-computed expectations.
module tb_muldiv_seq_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic [5:0]  req_rd;
    logic        ready, stall, kill, early_wake, wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic [5:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_unit #(.XLEN(32), .TAG_W(5), .PRF_W(6), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .req_tag_i(req_tag), .req_rd_i(req_rd),
        .ready_o(ready), .stall_i(stall), .kill_i(kill),
        .early_wake_o(early_wake), .wb_valid_o(wb_valid),
        .wb_data_o(wb_data), .wb_tag_o(wb_tag), .wb_rd_o(wb_rd)
    );

    // Present a request for one cycle; returns just after the accepting edge (start of cycle 1)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [5:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Record per-cycle behaviour for a bounded number of cycles after the accept
    task automatic observe(input int max_cyc, output int wake_cyc, output int wb_cyc,
                           output int wb_cnt, output logic [31:0] data, output logic [4:0] tg,
                           output logic [5:0] rdo, output int ready_cyc);
        wake_cyc = -1; wb_cyc = -1; wb_cnt = 0; ready_cyc = -1;
        data = '0; tg = '0; rdo = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (early_wake && wake_cyc < 0) wake_cyc = k;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_cyc < 0) begin
                    wb_cyc = k; data = wb_data; tg = wb_tag; rdo = wb_rd;
                end
            end
            if (ready && wb_cyc >= 0 && ready_cyc < 0) ready_cyc = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_tag = '0; req_rd = '0; stall = 1'b0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (early_wake !== 1'b0) begin errors++; $display("FAIL reset_early_wake: got %b expected 0", early_wake); end
        checks++; if ({wb_data, wb_tag, wb_rd} !== 43'd0) begin errors++; $display("FAIL reset_wb_fields: got %h/%h/%h expected 0", wb_data, wb_tag, wb_rd); end
    endtask

    task automatic test_mul();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, 6'd17);
        observe(8, wk, wc, n, d, t, r, rc);
        checks++; if (wk !== 2) begin errors++; $display("FAIL mul_wake_cyc: got %0d expected 2", wk); end
        checks++; if (wc !== 3) begin errors++; $display("FAIL mul_wb_cyc: got %0d expected 3", wc); end
        checks++; if (n !== 1) begin errors++; $display("FAIL mul_wb_count: got %0d expected 1", n); end
        checks++; if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h expected ffffffeb", d); end
        checks++; if (t !== 5'd9) begin errors++; $display("FAIL mul_tag: got %0d expected 9", t); end
        checks++; if (r !== 6'd17) begin errors++; $display("FAIL mul_rd: got %0d expected 17", r); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL mul_ready_cyc: got %0d expected 4", rc); end
    endtask

    task automatic test_mul_high();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        logic [2:0]  ops [3] = '{OP_MULHU, OP_MULHSU, OP_MULH};
        logic [31:0] av  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bv  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], av[i], bv[i], 5'(i + 1), 6'(i + 20));
            observe(6, wk, wc, n, d, t, r, rc);
            checks++; if (d !== exp[i]) begin errors++; $display("FAIL mulhi_data[%0d]: got %h expected %h", i, d, exp[i]); end
            checks++; if (wc !== 3) begin errors++; $display("FAIL mulhi_wb_cyc[%0d]: got %0d expected 3", i, wc); end
        end
    endtask

    task automatic test_div();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        issue(OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd4, 6'd5);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_data: got %h expected fffffffa", d); end
        checks++; if (wc !== 34) begin errors++; $display("FAIL div_wb_cyc: got %0d expected 34", wc); end
        checks++; if (wk !== 33) begin errors++; $display("FAIL div_wake_cyc: got %0d expected 33", wk); end
        checks++; if (n !== 1) begin errors++; $display("FAIL div_wb_count: got %0d expected 1", n); end
        issue(OP_REM, 32'hFFFF_FFEC, 32'd3, 5'd6, 6'd7);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_data: got %h expected fffffffe", d); end
        issue(OP_REMU, 32'd20, 32'd3, 5'd8, 6'd9);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_data: got %h expected 2", d); end
        issue(OP_DIVU, 32'd20, 32'd3, 5'd10, 6'd11);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL divu_data: got %h expected 6", d); end
    endtask

    task automatic test_fast_path();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        logic [2:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], av[i], bv[i], 5'(i + 12), 6'(i + 30));
            observe(4, wk, wc, n, d, t, r, rc);
            checks++; if (d !== exp[i]) begin errors++; $display("FAIL fast_data[%0d]: got %h expected %h", i, d, exp[i]); end
            checks++; if (wc !== 1) begin errors++; $display("FAIL fast_wb_cyc[%0d]: got %0d expected 1", i, wc); end
            checks++; if (wk !== -1) begin errors++; $display("FAIL fast_no_wake[%0d]: got %0d expected -1", i, wk); end
            checks++; if (t !== 5'(i + 12)) begin errors++; $display("FAIL fast_tag[%0d]: got %0d expected %0d", i, t, i + 12); end
        end
    endtask

    task automatic test_kill();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        issue(OP_DIV, 32'd100, 32'd7, 5'd2, 6'd3);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        checks++; if (early_wake !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL kill_outputs_c10: got wake %b valid %b expected 0 0", early_wake, wb_valid); end
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kill_ready_c11: got %b expected 1", ready); end
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (n !== 0) begin errors++; $display("FAIL kill_no_wb: got %0d pulses expected 0", n); end
        // Request together with kill must be dropped
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd9; req_b = 32'd9; kill = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kill_req_ready: got %b expected 1", ready); end
        observe(6, wk, wc, n, d, t, r, rc);
        checks++; if (n !== 0) begin errors++; $display("FAIL kill_req_no_wb: got %0d pulses expected 0", n); end
        issue(OP_MUL, 32'd3, 32'd4, 5'd1, 6'd2);
        observe(6, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'd12 || wc !== 3) begin errors++; $display("FAIL kill_after_mul: got %h at cycle %0d expected 0000000c at cycle 3", d, wc); end
    endtask

    task automatic test_stall_done();
        issue(OP_MUL, 32'd5, 32'd6, 5'd3, 6'd4);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== 32'd30 || wb_tag !== 5'd3 || wb_rd !== 6'd4) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid %b data %h tag %0d rd %0d expected 1 0000001e 3 4", i, wb_valid, wb_data, wb_tag, wb_rd);
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_last_valid: got %b expected 1", wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid %b ready %b expected 0 1", wb_valid, ready); end
    endtask

    task automatic test_early_out();
        int wk, wc, n, rc; logic [31:0] d; logic [4:0] t; logic [5:0] r;
        int exp_cyc;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        exp_cyc = 1;
`else
        exp_cyc = 34;
`endif
        issue(OP_DIVU, 32'd3, 32'd10, 5'd7, 6'd8);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL early_divu_data: got %h expected 0", d); end
        checks++; if (wc !== exp_cyc) begin errors++; $display("FAIL early_divu_cyc: got %0d expected %0d", wc, exp_cyc); end
        issue(OP_REM, 32'hFFFF_FFFD, 32'd10, 5'd7, 6'd8);
        observe(40, wk, wc, n, d, t, r, rc);
        checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL early_rem_data: got %h expected fffffffd", d); end
        checks++; if (wc !== exp_cyc) begin errors++; $display("FAIL early_rem_cyc: got %0d expected %0d", wc, exp_cyc); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_kill();
        test_stall_done();
        test_early_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

- Parametrised multiply/divide execution unit for the integer issue path, with one operation in flight at a time.
- Implements all eight RV32M/RV64M-style operations for XLEN-bit operands: a pipelined multiplier of configurable depth and a radix-2 iterative divider with fast paths.
- Returns the ROB tag and destination PRF address with the result, and raises an early-wake strobe one cycle before write-back.
- Supports stall freeze and kill of the in-flight operation.
- Sits beside the ALU in an ALU/MUL/DIV execute group, and drives that group's mul/div write-back and broadcast ports.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- TAG_W, 5, ROB tag width
- PRF_W, 6, physical register specifier width
- MUL_STAGES, 2, multiplier pipeline cycles (≥1)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request strobe
- req_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a_i, req_b_i  in  XLEN  operands (rs1, rs2)
- req_tag_i  in  TAG_W  ROB tag
- req_rd_i  in  PRF_W  destination PRF address
- ready_o  out  1  unit idle, can accept
- stall_i  in  1  freeze all state and outputs
- kill_i  in  1  abandon in-flight op
- early_wake_o  out  1  write-back occurs next un-stalled cycle
- wb_valid_o  out  1  result valid (one-cycle pulse unless stalled)
- wb_data_o  out  XLEN  result
- wb_tag_o  out  TAG_W  tag of result
- wb_rd_o  out  PRF_W  rd of result

## Operation

**Accept condition**
- Accept when req_valid_i && ready_o && !stall_i && !kill_i.
- On accept, register the operands, op, tag and rd.
- A request presented when ready_o=0 is ignored; the issue queue holds it.

**States:** IDLE, MUL, DIV, FIX, DONE. ready_o = (state==IDLE).
- IDLE→MUL: accepted op[2]=0. The counter loads MUL_STAGES-1.
- IDLE→DIV: accepted op[2]=1, no fast path. The counter loads XLEN-1.
- IDLE→DONE (fast path):
  - divisor zero: quotient all-ones; remainder = dividend.
  - signed overflow (DIV/REM with a = 2^(XLEN-1), b = -1): quotient = a; remainder 0.
- MUL→DONE when the counter is 0; otherwise decrement.
  - Product is 2·XLEN bits.
  - MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Signedness: MULH s×s, MULHSU s×u, MULHU u×u.
- DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle. DIV→FIX when the counter is 0.
- FIX→DONE: negate the quotient if the operand signs differ (signed ops). The remainder takes the dividend's sign.
- DONE→IDLE unconditionally when not stalled.

**Outputs and control**
- wb_valid_o = (state==DONE) && !kill_i.
- wb_data_o, wb_tag_o and wb_rd_o are registered and stable throughout DONE.
- early_wake_o = ((state==MUL && cnt==0) || state==FIX) && !kill_i. It is not asserted for fast-path ops.
- kill_i: any state→IDLE next edge with no write-back. Kill takes priority over stall and over accept.
- stall_i (without kill): state, counter, datapath and all outputs hold. wb_valid_o is re-presented each stalled cycle.
- Reset: state IDLE, counter 0, wb_valid_o 0, early_wake_o 0, wb_data_o/wb_tag_o/wb_rd_o 0, ready_o 1.

## Timing
Accept in cycle 0. wb_valid_o is high in:
- MUL ops: cycle MUL_STAGES+1.
- Normal divide: cycle XLEN+2.
- Fast path: cycle 1.

Stall cycles add one-for-one. The next accept is possible in the cycle after DONE (throughput: one op per latency+1 cycles).

## Configuration
- MULDIV_DIV_EARLY_OUT_EN
  - Defined: a divide with b≠0 and |a| < |b| (magnitudes; unsigned for DIVU/REMU) takes the fast path to DONE in cycle 1. Quotient 0; remainder = original a.
  - Undefined: such divides run the full XLEN iterations and produce the same values at cycle XLEN+2.

## Test plan
Defaults XLEN=32, MUL_STAGES=2; cycle numbers are relative to the accept cycle (cycle 0).
1. MUL a=7, b=0xFFFFFFFD, tag 9, rd 17:
   - early_wake_o high in cycle 2.
   - wb_valid_o high in cycle 3 only; wb_data_o=0xFFFFFFEB, wb_tag_o=9, wb_rd_o=17.
   - ready_o high in cycle 4.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULH 0x80000000×0x80000000 → 0x40000000.
3. Signed divide, no early-out (operands chosen so |a| ≥ |b|):
   - DIV −20/3 → 0xFFFFFFFA, wb_valid_o in cycle 34, early_wake_o in cycle 33.
   - REM −20/3 → 0xFFFFFFFE.
   - REMU 20/3 → 2.
4. Fast paths, each with wb_valid_o in cycle 1:
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
5. Kill:
   - Kill in cycle 10 of a DIV → no wb_valid_o ever; ready_o=1 in cycle 11.
   - Kill asserted together with a request → request not accepted.
   - A following MUL 3×4 → 12 at the normal latency.
6. Stall and early-out:
   - Stall 5 cycles while in DONE → wb_valid_o held high with data/tag unchanged, then exactly one further valid cycle.
   - DIVU 3/10 with MULDIV_DIV_EARLY_OUT_EN → 0 in cycle 1; without the macro → 0 in cycle 34.
